// File: rtl/nano_rv32i_mem_pkg.sv
// Shared types and constants for the nano_rv32i_mem instruction/data memory.
package nano_rv32i_mem_pkg;

    localparam int          WAIT_W     = 3;
    localparam int          BYTE_LANES = 4;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } port_state_t;

endpackage

// File: rtl/nano_rv32i_mem_port.sv
// One access port: IDLE/WAIT/RESP handshake FSM, wait-state counter and request latches.
module nano_rv32i_mem_port
    import nano_rv32i_mem_pkg::*;
#(
    parameter int WAIT = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  rd_i,
    input  logic                  wr_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           data_i,
    input  logic [BYTE_LANES-1:0] be_i,
    output logic                  resp_o,
    output logic                  wr_o,
    output logic [31:0]           addr_o,
    output logic [31:0]           data_o,
    output logic [BYTE_LANES-1:0] be_o
);

    localparam logic [WAIT_W-1:0] CNT_INIT = (WAIT > 0) ? WAIT_W'(WAIT - 1) : '0;

    port_state_t           state_q, state_d;
    logic [WAIT_W-1:0]     cnt_q, cnt_d;
    logic                  accept;
    logic                  wr_q;
    logic [31:0]           addr_q, data_q;
    logic [BYTE_LANES-1:0] be_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_i || wr_i) begin
                    accept = 1'b1;
                    if (WAIT > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A simultaneous read and write is latched as a write.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            wr_q   <= wr_i;
            addr_q <= addr_i;
            data_q <= data_i;
            be_q   <= be_i;
        end
    end

    // Gating with reset keeps an aborted access from ever showing a response.
    assign resp_o = (state_q == ST_RESP) && rst_n_i;
    assign wr_o   = wr_q;
    assign addr_o = addr_q;
    assign data_o = data_q;
    assign be_o   = be_q;

endmodule

// File: rtl/nano_rv32i_mem.sv
// nano_rv32i_mem: shared word memory with independent instruction and data ports.
// Define NANO_RV32I_MEM_ERR_EN to add range/alignment checking and the d_err_o flag.
module nano_rv32i_mem
    import nano_rv32i_mem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 32,
    parameter int    I_WAIT      = 0,
    parameter int    D_WAIT      = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  i_rd_i,
    input  logic [31:0]           i_addr_i,
    output logic [31:0]           i_data_o,
    output logic                  i_valid_o,
    input  logic                  d_rd_i,
    input  logic                  d_wr_i,
    input  logic [31:0]           d_addr_i,
    input  logic [31:0]           d_data_i,
    input  logic [BYTE_LANES-1:0] d_be_i,
    output logic [31:0]           d_data_o,
`ifdef NANO_RV32I_MEM_ERR_EN
    output logic                  d_err_o,
`endif
    output logic                  d_valid_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    logic                  i_resp, d_resp, d_wr_q;
    logic [31:0]           i_addr_q, d_addr_q, d_wdata_q;
    logic [BYTE_LANES-1:0] d_be_q;
    logic                  i_unused_wr;
    logic [31:0]           i_unused_data;
    logic [BYTE_LANES-1:0] i_unused_be;

    nano_rv32i_mem_port #(.WAIT(I_WAIT)) u_i_port (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .rd_i    (i_rd_i),
        .wr_i    (1'b0),
        .addr_i  (i_addr_i),
        .data_i  (32'h0),
        .be_i    ('0),
        .resp_o  (i_resp),
        .wr_o    (i_unused_wr),
        .addr_o  (i_addr_q),
        .data_o  (i_unused_data),
        .be_o    (i_unused_be)
    );

    nano_rv32i_mem_port #(.WAIT(D_WAIT)) u_d_port (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .rd_i    (d_rd_i),
        .wr_i    (d_wr_i),
        .addr_i  (d_addr_i),
        .data_i  (d_data_i),
        .be_i    (d_be_i),
        .resp_o  (d_resp),
        .wr_o    (d_wr_q),
        .addr_o  (d_addr_q),
        .data_o  (d_wdata_q),
        .be_o    (d_be_q)
    );

    logic [AW-1:0] i_idx, d_idx;
    logic          i_err, d_err;

    assign i_idx = i_addr_q[AW+1:2];
    assign d_idx = d_addr_q[AW+1:2];

`ifdef NANO_RV32I_MEM_ERR_EN
    assign i_err   = (i_addr_q[31:AW+2] != '0) || (i_addr_q[1:0] != 2'b00);
    assign d_err   = (d_addr_q[31:AW+2] != '0) || (d_addr_q[1:0] != 2'b00);
    assign d_err_o = d_resp && d_err;
`else
    // Upper and sub-word address bits are dropped so accesses wrap around the array.
    logic addr_unused;
    assign addr_unused = ^{i_addr_q[31:AW+2], i_addr_q[1:0], d_addr_q[31:AW+2], d_addr_q[1:0]};
    assign i_err = 1'b0;
    assign d_err = 1'b0;
`endif

    logic [31:0] i_rd_word, d_rd_word, d_merged, d_resp_data;
    logic [31:0] i_hold_q, d_hold_q;
    logic        d_we;

    // Both ports read the pre-write word during RESP; the write lands at the closing edge.
    assign i_rd_word = mem[i_idx];
    assign d_rd_word = mem[d_idx];
    assign d_we      = d_resp && d_wr_q && !d_err;

    always_comb begin
        d_merged = d_rd_word;
        for (int b = 0; b < BYTE_LANES; b++) begin
            if (d_be_q[b]) d_merged[8*b +: 8] = d_wdata_q[8*b +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (d_we) mem[d_idx] <= d_merged;
    end

    assign d_resp_data = d_err ? 32'h0 : (d_wr_q ? d_hold_q : d_rd_word);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            i_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            if (i_resp) i_hold_q <= i_err ? NOP_INSN : i_rd_word;
            if (d_resp) d_hold_q <= d_resp_data;
        end
    end

    assign i_data_o  = i_resp ? (i_err ? NOP_INSN : i_rd_word) : i_hold_q;
    assign d_data_o  = d_resp ? d_resp_data : d_hold_q;
    assign i_valid_o = i_resp;
    assign d_valid_o = d_resp;

endmodule

// File: tb/tb_nano_rv32i_mem.sv
// Scoreboard bench for nano_rv32i_mem: instance 0 has no wait states, instance 1 has I_WAIT=2, D_WAIT=3.
module tb_nano_rv32i_mem;
    import nano_rv32i_mem_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        i_rd [2], d_rd [2], d_wr [2];
    logic        i_valid [2], d_valid [2], d_err [2];
    logic [31:0] i_addr [2], d_addr [2], d_wdata [2], i_rdata [2], d_rdata [2];
    logic [3:0]  d_be [2];

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb [4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nano_rv32i_mem #(.DEPTH_WORDS(32), .I_WAIT(0), .D_WAIT(0), .INIT_FILE("")) dut_a (
        .clk_i(clk), .rst_n_i(rst_n[0]),
        .i_rd_i(i_rd[0]), .i_addr_i(i_addr[0]), .i_data_o(i_rdata[0]), .i_valid_o(i_valid[0]),
        .d_rd_i(d_rd[0]), .d_wr_i(d_wr[0]), .d_addr_i(d_addr[0]), .d_data_i(d_wdata[0]),
        .d_be_i(d_be[0]), .d_data_o(d_rdata[0]),
`ifdef NANO_RV32I_MEM_ERR_EN
        .d_err_o(d_err[0]),
`endif
        .d_valid_o(d_valid[0])
    );

    nano_rv32i_mem #(.DEPTH_WORDS(32), .I_WAIT(2), .D_WAIT(3), .INIT_FILE("")) dut_b (
        .clk_i(clk), .rst_n_i(rst_n[1]),
        .i_rd_i(i_rd[1]), .i_addr_i(i_addr[1]), .i_data_o(i_rdata[1]), .i_valid_o(i_valid[1]),
        .d_rd_i(d_rd[1]), .d_wr_i(d_wr[1]), .d_addr_i(d_addr[1]), .d_data_i(d_wdata[1]),
        .d_be_i(d_be[1]), .d_data_o(d_rdata[1]),
`ifdef NANO_RV32I_MEM_ERR_EN
        .d_err_o(d_err[1]),
`endif
        .d_valid_o(d_valid[1])
    );

`ifndef NANO_RV32I_MEM_ERR_EN
    assign d_err[0] = 1'b0;
    assign d_err[1] = 1'b0;
`endif

    function automatic int dwait(int sel);
        return (sel == 0) ? 0 : 3;
    endfunction

    function automatic int iwait(int sel);
        return (sel == 0) ? 0 : 2;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push(int k, string name, logic [31:0] data, logic err, int due);
        exp_t e;
        e.name = name;
        e.data = data;
        e.err  = err;
        e.due  = due;
        sb[k].push_back(e);
    endtask

    task automatic mon(int k, logic vld, logic [31:0] data, logic err);
        exp_t e;
        if (vld) begin
            checks++;
            if (sb[k].size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid stream=%0d cyc=%0d got=1 exp=0", k, cyc);
            end else begin
                e = sb[k].pop_front();
                if (data !== e.data || err !== e.err || cyc != e.due) begin
                    failures++;
                    $display("FAIL %s data=%h exp=%h err=%b exp_err=%b cyc=%0d exp_cyc=%0d",
                             e.name, data, e.data, err, e.err, cyc, e.due);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                mon(s * 2, i_valid[s], i_rdata[s], 1'b0);
                mon(s * 2 + 1, d_valid[s], d_rdata[s], d_err[s]);
            end
        end
    end

    task automatic wait_valid(int sel, bit dport, bit poke);
        int n   = 0;
        bit got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (poke && n == 2) d_addr[sel] = d_addr[sel] ^ 32'h0000_000C;
            got = dport ? d_valid[sel] : i_valid[sel];
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL timeout sel=%0d dport=%0d got=0 exp=1", sel, dport);
        end
    endtask

    task automatic d_access(int sel, bit wr, bit rd, logic [31:0] addr, logic [31:0] wdata,
                            logic [3:0] be, string name, logic [31:0] exp, logic err, bit poke);
        push(sel * 2 + 1, name, exp, err, cyc + 1 + dwait(sel));
        d_rd[sel]    = rd;
        d_wr[sel]    = wr;
        d_addr[sel]  = addr;
        d_wdata[sel] = wdata;
        d_be[sel]    = be;
        wait_valid(sel, 1'b1, poke);
        d_rd[sel] = 1'b0;
        d_wr[sel] = 1'b0;
        @(negedge clk);
    endtask

    task automatic i_access(int sel, logic [31:0] addr, string name, logic [31:0] exp);
        push(sel * 2, name, exp, 1'b0, cyc + 1 + iwait(sel));
        i_rd[sel]   = 1'b1;
        i_addr[sel] = addr;
        wait_valid(sel, 1'b0, 1'b0);
        i_rd[sel] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst_n[s] = 1'b0; i_rd[s] = 1'b0; d_rd[s] = 1'b0; d_wr[s] = 1'b0;
            i_addr[s] = '0; d_addr[s] = '0; d_wdata[s] = '0; d_be[s] = '0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_i_valid", {31'b0, i_valid[s]}, 32'h0);
            chk("rst_d_valid", {31'b0, d_valid[s]}, 32'h0);
            chk("rst_i_data", i_rdata[s], 32'h0);
            chk("rst_d_data", d_rdata[s], 32'h0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        d_access(0, 1, 0, 32'h8,  32'hDEADBEEF, 4'b1111, "a_wr_8", 32'h0, 1'b0, 1'b0);
        d_access(0, 0, 1, 32'h8,  32'h0,        4'b0000, "a_rd_8", 32'hDEADBEEF, 1'b0, 1'b0);
        chk("a_hold_data", d_rdata[0], 32'hDEADBEEF);
        chk("a_hold_valid", {31'b0, d_valid[0]}, 32'h0);
        d_access(0, 1, 0, 32'h10, 32'h11223344, 4'b1111, "a_wr_10", 32'hDEADBEEF, 1'b0, 1'b0);
        d_access(0, 1, 1, 32'h10, 32'hAABBCCDD, 4'b0101, "a_wr_be", 32'hDEADBEEF, 1'b0, 1'b0);
        d_access(0, 0, 1, 32'h10, 32'h0,        4'b0000, "a_rd_be", 32'h11BB33DD, 1'b0, 1'b0);
        d_access(0, 1, 0, 32'h8,  32'h00500093, 4'b1111, "a_wr_insn", 32'h11BB33DD, 1'b0, 1'b0);

        // Same-cycle instruction read and data write to word 2.
        push(0, "a_rbw_i", 32'h00500093, 1'b0, cyc + 1);
        push(1, "a_rbw_d", 32'h11BB33DD, 1'b0, cyc + 1);
        i_rd[0] = 1'b1; i_addr[0] = 32'h8;
        d_wr[0] = 1'b1; d_addr[0] = 32'h8; d_wdata[0] = 32'h55; d_be[0] = 4'b1111;
        wait_valid(0, 1'b1, 1'b0);
        i_rd[0] = 1'b0; d_wr[0] = 1'b0;
        @(negedge clk);

        d_access(0, 0, 1, 32'h8, 32'h0, 4'b0000, "a_rd_after_rbw", 32'h55, 1'b0, 1'b0);
        i_access(0, 32'h8, "a_i_rd_8", 32'h55);
        d_access(0, 1, 0, 32'h0, 32'hCAFEF00D, 4'b1111, "a_wr_0", 32'h55, 1'b0, 1'b0);
`ifdef NANO_RV32I_MEM_ERR_EN
        d_access(0, 0, 1, 32'h80, 32'h0, 4'b0000, "a_err_range", 32'h0, 1'b1, 1'b0);
        i_access(0, 32'h80, "a_i_err_nop", NOP_INSN);
        d_access(0, 1, 0, 32'h2, 32'hFFFFFFFF, 4'b1111, "a_err_align", 32'h0, 1'b1, 1'b0);
        d_access(0, 0, 1, 32'h0, 32'h0, 4'b0000, "a_rd_0_kept", 32'hCAFEF00D, 1'b0, 1'b0);
`else
        d_access(0, 0, 1, 32'h80, 32'h0, 4'b0000, "a_rd_wrap", 32'hCAFEF00D, 1'b0, 1'b0);
        i_access(0, 32'h8B, "a_i_wrap", 32'h55);
`endif

        d_access(1, 1, 0, 32'h4, 32'h0BADF00D, 4'b1111, "b_wr_4", 32'h0, 1'b0, 1'b0);
        d_access(1, 0, 1, 32'h4, 32'h0, 4'b0000, "b_rd_4_ignore2nd", 32'h0BADF00D, 1'b0, 1'b1);
        chk("b_hold_data", d_rdata[1], 32'h0BADF00D);
        chk("b_hold_valid", {31'b0, d_valid[1]}, 32'h0);
        d_access(1, 1, 0, 32'hC, 32'h12345678, 4'b1111, "b_wr_c", 32'h0BADF00D, 1'b0, 1'b0);

        // Reset lands while the write sits in WAIT.
        d_wr[1] = 1'b1; d_addr[1] = 32'hC; d_wdata[1] = 32'hFFFFFFFF; d_be[1] = 4'b1111;
        repeat (2) @(negedge clk);
        rst_n[1] = 1'b0;
        d_wr[1]  = 1'b0;
        @(negedge clk);
        chk("b_rst_d_valid", {31'b0, d_valid[1]}, 32'h0);
        chk("b_rst_i_valid", {31'b0, i_valid[1]}, 32'h0);
        chk("b_rst_d_data", d_rdata[1], 32'h0);
        rst_n[1] = 1'b1;
        i_access(1, 32'hC, "b_i_after_rst", 32'h12345678);
        d_access(1, 0, 1, 32'hC, 32'h0, 4'b0000, "b_rd_c_unchanged", 32'h12345678, 1'b0, 1'b0);

        repeat (6) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (sb[k].size() != 0) begin
                failures++;
                $display("FAIL pending_responses stream=%0d got=%0d exp=0", k, sb[k].size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nano_rv32i_mem.md
NANO_RV32I_MEM -- requirements
Module: nano_rv32i_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 32, meaning the number of 32-bit words shared by both ports (power of two, 16..65536).
REQ-002 SHALL have parameter I_WAIT, default 0, meaning instruction-port wait states (0..7).
REQ-003 SHALL have parameter D_WAIT, default 0, meaning data-port wait states (0..7).
REQ-004 SHALL have parameter INIT_FILE, default "", meaning a hex image loaded by $readmemh at elaboration when non-empty.
REQ-005 SHALL have one clock; reset is synchronous and active-low, with ports clk_i (in, 1, clock) and rst_n_i (in, 1, reset).
REQ-006 SHALL have port i_rd_i (in, 1) as the instruction read request.
REQ-007 SHALL have port i_addr_i (in, 32) as the instruction byte address.
REQ-008 SHALL have port i_data_o (out, 32) as the instruction word.
REQ-009 SHALL have port i_valid_o (out, 1) as the instruction response strobe.
REQ-010 SHALL have ports d_rd_i (in, 1) and d_wr_i (in, 1) as the data read and write requests.
REQ-011 SHALL have port d_addr_i (in, 32) as the data byte address.
REQ-012 SHALL have ports d_data_i (in, 32) as write data and d_be_i (in, 4) as write byte enables.
REQ-013 SHALL have ports d_data_o (out, 32) as read data and d_valid_o (out, 1) as the data response strobe.
REQ-014 SHALL have port d_err_o (out, 1) as the error flag, present only when NANO_RV32I_MEM_ERR_EN is defined.

Function
REQ-015 Each port SHALL run an independent FSM with states IDLE, WAIT and RESP.
REQ-016 IDLE SHALL accept a request (rd or wr high) on the clock edge, latch address, data and be, then go to WAIT if WAIT>0, else to RESP.
REQ-017 WAIT SHALL decrement a 3-bit counter loaded with WAIT-1, and SHALL go to RESP when the counter reaches 0.
REQ-018 RESP SHALL assert valid for exactly one cycle, then return to IDLE; request-to-valid latency is WAIT+1 cycles.
REQ-019 Requests arriving in WAIT or RESP SHALL be ignored, and the requester SHALL hold the request until valid, so back-to-back accesses sustain one access per WAIT+2 cycles.
REQ-020 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2], and addr[1:0] SHALL be ignored for indexing.
REQ-021 A read SHALL sample memory in the RESP cycle and hold data_o until the next response; data_o SHALL be 0 after reset until the first read.
REQ-022 A write SHALL commit in the RESP cycle, updating only the byte lanes with d_be_i=1; d_data_o SHALL be unchanged on a write response.
REQ-023 If d_rd_i and d_wr_i are both high at acceptance, the access SHALL be treated as a write.
REQ-024 If an instruction read and a data write hit the same word in the same RESP cycle, the instruction port SHALL return the old word (read-before-write).
REQ-025 Without NANO_RV32I_MEM_ERR_EN, addresses SHALL wrap modulo DEPTH_WORDS*4.

Reset
REQ-026 While rst_n_i=0 at the clock edge, both FSMs SHALL go to IDLE, the counters SHALL clear, valids SHALL be 0, data_o SHALL be 0 and d_err_o SHALL be 0.
REQ-027 Reset during WAIT or RESP SHALL abort the pending access: no write commit and no valid.
REQ-028 Memory contents SHALL NOT be altered by reset.

Configuration
REQ-029 With NANO_RV32I_MEM_ERR_EN defined, a data access whose address is at or beyond DEPTH_WORDS*4 or has addr[1:0]!=0 SHALL respond with d_valid_o=1 and d_err_o=1 in the same cycle, d_data_o=0, and no write; the instruction port SHALL apply the same range check with i_data_o=0x00000013 (NOP).
REQ-030 Without NANO_RV32I_MEM_ERR_EN, the d_err_o port SHALL be absent and REQ-025 SHALL apply.

Structure
REQ-031 Package nano_rv32i_mem_pkg SHALL hold the FSM state enum, WAIT_W=3, the NOP constant 0x00000013 and the byte-lane count 4.
REQ-032 Sub-module nano_rv32i_mem_port (FSM, wait counter, latches) SHALL be instantiated once per port; the storage array and byte-enable merge SHALL live in the top.

Verification
REQ-033 With D_WAIT=0, write 0xDEADBEEF to 0x8 with be=1111, then read 0x8 -> d_valid_o 1 cycle after each request, and the read returns 0xDEADBEEF.
REQ-034 With D_WAIT=3, read 0x4 -> d_valid_o exactly 4 cycles after acceptance and high for 1 cycle; a second request during WAIT is ignored.
REQ-035 Store 0x11223344, then write 0xAABBCCDD with be=0101 -> the read returns 0x11BB33DD.
REQ-036 Issue a same-cycle instruction read and data write of 0x55 to word 2, where word 2 holds 0x00500093 -> the instruction port returns 0x00500093 and a later read returns 0x55.
REQ-037 Assert reset in the WAIT state of a write -> no valid, word unchanged, and both ports in IDLE the next cycle.
REQ-038 With ERR_EN and DEPTH_WORDS=32, read 0x80 -> d_err_o=1 and data 0; without ERR_EN the same read returns word 0.
